conv1d_sys_sequencer: RTL and testbench
=======================================

// Module: conv1d_sys_sequencer
// PURPOSE
//  Controller for the pipelined 1-D convolution systolic array.
//  Per job it does four things in order:
//   - loads NTAPS weights into the PE internal registers;
//   - streams cfg_len samples into the array, then NTAPS-1 zero samples to flush it;
//   - captures one array sum per trigger after PIPE_LAT cycles;
//   - returns the full convolution (cfg_len+NTAPS-1 results) on a valid/ready stream.
//  Sits between the job or DMA logic and the systolic array instance.
// PARAMETERS
//  DW        32  data width of weights, samples, sums and pe_wen_idx
//  NTAPS     10  number of PEs / filter taps
//  LEN_W     16  width of cfg_len
//  PIPE_LAT  2   cycles from pe_trigger to the matching valid pe_sum
//  FIFO_D    4   output FIFO depth, >= PIPE_LAT+1
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset: synchronous, active-high
//  start       in   1      job start pulse; sampled only in IDLE
//  cfg_len     in   LEN_W  number of input samples N
//  busy        out  1      high from start acceptance until done
//  done        out  1      one-cycle pulse when the job completes
//  w_valid     in   1      weight stream valid
//  w_ready     out  1      weight stream ready
//  w_data      in   DW     weight stream data, tap 0 first
//  x_valid     in   1      sample stream valid
//  x_ready     out  1      sample stream ready
//  x_data      in   DW     sample stream data
//  y_valid     out  1      result stream valid
//  y_ready     in   1      result stream ready
//  y_data      out  DW     result stream data
//  y_last      out  1      marks the final result of the job
//  pe_rst      out  1      array reset
//  pe_trigger  out  1      array trigger
//  pe_din      out  DW     array sample input
//  pe_wen_idx  out  DW     PE weight write index, 1-based; 0 = no write
//  pe_wval     out  DW     PE weight write value
//  pe_sum      in   DW     array sum output
// BEHAVIOUR
//  Reset values: all outputs 0. FSM=IDLE. FIFO empty. All counters 0.
//  FSM states: IDLE -> CLEAR -> LOAD_W -> STREAM -> FLUSH -> DRAIN -> DONE -> IDLE.
//  IDLE
//   - start=1 latches cfg_len and asserts busy next cycle; go to CLEAR.
//  CLEAR (1 cycle)
//   - pe_rst=1 to zero stale array pipeline state.
//  LOAD_W
//   - w_ready=1. On each w_valid&&w_ready: pe_wen_idx=k+1, pe_wval=w_data, k++.
//   - After tap NTAPS-1: go to STREAM, or to DONE if N==0 (no y produced).
//  STREAM
//   - x_ready = can_issue, where can_issue = (fifo_cnt + inflight) < FIFO_D.
//   - On x_valid&&x_ready: pe_din=x_data, pe_trigger=1.
//   - After N accepted samples, go to FLUSH.
//  FLUSH
//   - Issues NTAPS-1 triggers with pe_din=0, each gated by can_issue; then go to DRAIN.
//  DRAIN
//   - Waits until inflight==0 and the FIFO is empty; then go to DONE.
//  DONE
//   - done=1 for one cycle, busy=0; go to IDLE.
//  pe_trigger=0 in every cycle without an issue. The array holds state while stalled.
//  Capture: a PIPE_LAT-deep shift register of issue bits; when its output is 1, pe_sum is pushed
//   into the FIFO. can_issue guarantees the push never overflows.
//  y_valid = FIFO non-empty; y_data = FIFO head; pop on y_valid&&y_ready.
//  y_last is 1 on output index N+NTAPS-2.
//  Simultaneous push and pop in one cycle: fifo_cnt is unchanged.
//  Full-rate streaming with y_ready held at 1: one issue per cycle, no bubbles.
//  Arithmetic: the sum is taken modulo 2^DW as produced by the array; the sequencer adds no arithmetic.
//  start while busy: ignored.
//  rst mid-job: FSM -> IDLE, FIFO and inflight flushed, pe_rst=1 while rst is high.
//   Already-loaded PE weights stay undefined-stale.
// CONFIGURATION
//  CONV1D_SEQ_PERF_EN defined: adds two outputs, cleared on start, frozen at done:
//   - perf_cycles [31:0]: busy cycle count.
//   - perf_stalls [31:0]: cycles in STREAM/FLUSH with can_issue=0.
//  Undefined: neither port nor its counter logic exists.
// STRUCTURE
//  Shared package conv1d_seq_pkg holds:
//   - the FSM state enum (IDLE..DONE);
//   - default DW, NTAPS and PIPE_LAT localparams;
//   - the PE index encoding: 0 = none, k+1 = tap k.
//  One sub-module: conv1d_seq_out_fifo
//   - synchronous FIFO of FIFO_D x DW;
//   - outputs count/empty/full; flush input.
// TESTING (bench includes a behavioural array model, NTAPS=3 override)
//  1. w={1,2,3}, x={1,1}, y_ready=1 -> y={1,3,5,3}; y_last on 4th; done 1 cycle after drain.
//  2. w={1,2,3}, x={1,2,3,4}, y_ready toggled 1/0 each cycle
//     -> y={1,4,10,16,17,12}; no loss or dup; pe_trigger never issued with FIFO overcommitted.
//  3. cfg_len=0 -> 3 weight writes (pe_wen_idx 1,2,3), done, zero y beats, busy low after.
//  4. rst asserted mid-STREAM, then a new job w={2,0,0}, x={5}
//     -> y={10,0,0}, no stale results from the aborted job.
//  5. start pulsed while busy -> ignored; start in IDLE with x_valid held low
//     -> FSM waits in STREAM, pe_trigger stays 0.
//  6. CONV1D_SEQ_PERF_EN, test 2 stimulus -> perf_stalls > 0; perf_cycles equals the busy-high cycle count.

Source files
------------

// File: rtl/conv1d_seq_pkg.sv
// rtl/conv1d_seq_pkg.sv - shared types and defaults for the conv1d systolic sequencer
package conv1d_seq_pkg;

    localparam int DEF_DW       = 32;
    localparam int DEF_NTAPS    = 10;
    localparam int DEF_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // PE weight write index: 0 means no write, k+1 addresses tap k
    localparam logic [31:0] PE_IDX_NONE = 32'd0;

    function automatic logic [31:0] pe_idx(input int k);
        return 32'(k + 1);
    endfunction

endpackage

// File: rtl/conv1d_sys_sequencer_if.sv
// rtl/conv1d_sys_sequencer_if.sv - weight, sample and result streams of the conv1d sequencer
interface conv1d_sys_sequencer_if #(
    parameter int DW = 32
);
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          x_valid;
    logic          x_ready;
    logic [DW-1:0] x_data;
    logic          y_valid;
    logic          y_ready;
    logic [DW-1:0] y_data;
    logic          y_last;

    modport master (
        output w_valid, w_data, x_valid, x_data, y_ready,
        input  w_ready, x_ready, y_valid, y_data, y_last
    );

    modport slave (
        input  w_valid, w_data, x_valid, x_data, y_ready,
        output w_ready, x_ready, y_valid, y_data, y_last
    );
endinterface

// File: rtl/conv1d_seq_out_fifo.sv
// rtl/conv1d_seq_out_fifo.sv - synchronous result FIFO with count/empty/full and flush
module conv1d_seq_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DW-1:0]                din,
    input  logic                         pop,
    output logic [DW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/conv1d_sys_sequencer.sv
// rtl/conv1d_sys_sequencer.sv - job sequencer for the 1-D convolution systolic array
// Optional CONV1D_SEQ_PERF_EN adds perf_cycles/perf_stalls counters.
module conv1d_sys_sequencer
    import conv1d_seq_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int NTAPS    = DEF_NTAPS,
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int FIFO_D   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    output logic                  busy,
    output logic                  done,
    conv1d_sys_sequencer_if.slave bus,
    output logic                  pe_rst,
    output logic                  pe_trigger,
    output logic [DW-1:0]         pe_din,
    output logic [DW-1:0]         pe_wen_idx,
    output logic [DW-1:0]         pe_wval,
    input  logic [DW-1:0]         pe_sum
`ifdef CONV1D_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);
    localparam int CW    = $clog2(FIFO_D + 1);
    localparam int OUT_W = LEN_W + $clog2(NTAPS) + 1;

    seq_state_t            state;
    logic [LEN_W-1:0]      len_q, cnt;
    logic [OUT_W-1:0]      out_idx;
    logic [CW-1:0]         inflight, fifo_cnt;
    logic [PIPE_LAT-1:0]   cap_sr;
    logic                  clr_q;
    logic                  fifo_empty, fifo_full;
    logic                  can_issue, w_fire, x_fire, flush_fire, issue, push, pop;

    // Reserve FIFO space for every sum still travelling through the array
    assign can_issue  = (int'(fifo_cnt) + int'(inflight)) < FIFO_D;
    assign bus.w_ready = (state == S_LOAD_W);
    assign bus.x_ready = (state == S_STREAM) && can_issue;
    assign w_fire     = bus.w_valid && bus.w_ready;
    assign x_fire     = bus.x_valid && bus.x_ready;
    assign flush_fire = (state == S_FLUSH) && can_issue;
    assign issue      = x_fire || flush_fire;

    assign pe_rst     = rst || clr_q;
    assign pe_trigger = issue;
    assign pe_din     = x_fire ? bus.x_data : '0;
    assign pe_wen_idx = w_fire ? DW'(pe_idx(int'(cnt))) : DW'(PE_IDX_NONE);
    assign pe_wval    = w_fire ? bus.w_data : '0;

    assign push        = cap_sr[PIPE_LAT-1];
    assign bus.y_valid = !fifo_empty;
    assign pop         = bus.y_valid && bus.y_ready;
    assign bus.y_last  = bus.y_valid && (out_idx == OUT_W'(len_q) + OUT_W'(NTAPS - 2));

    conv1d_seq_out_fifo #(.DW(DW), .DEPTH(FIFO_D)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr_q),
        .push  (push),
        .din   (pe_sum),
        .pop   (pop),
        .dout  (bus.y_data),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            clr_q    <= 1'b0;
            len_q    <= '0;
            cnt      <= '0;
            out_idx  <= '0;
            inflight <= '0;
            cap_sr   <= '0;
        end else begin
            done     <= 1'b0;
            clr_q    <= 1'b0;
            cap_sr   <= (cap_sr << 1) | PIPE_LAT'(issue);
            inflight <= inflight + CW'(issue) - CW'(push);
            if (pop) out_idx <= out_idx + OUT_W'(1);
            case (state)
                S_IDLE: if (start) begin
                    len_q   <= cfg_len;
                    busy    <= 1'b1;
                    clr_q   <= 1'b1;
                    cnt     <= '0;
                    out_idx <= '0;
                    state   <= S_CLEAR;
                end
                S_CLEAR: begin
                    cap_sr   <= '0;
                    inflight <= '0;
                    state    <= S_LOAD_W;
                end
                S_LOAD_W: if (w_fire) begin
                    if (cnt == LEN_W'(NTAPS - 1)) begin
                        cnt <= '0;
                        if (len_q == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_STREAM;
                        end
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                S_STREAM: if (x_fire) begin
                    if (cnt == len_q - LEN_W'(1)) begin
                        cnt   <= '0;
                        state <= S_FLUSH;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                S_FLUSH: if (flush_fire) begin
                    if (cnt == LEN_W'(NTAPS - 2)) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                S_DRAIN: if (inflight == '0 && fifo_empty) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV1D_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 32'd1;
            if ((state == S_STREAM || state == S_FLUSH) && !can_issue)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1d_sys_sequencer.sv
// tb/tb_conv1d_sys_sequencer.sv - directed bench for conv1d_sys_sequencer with a 3-tap array model
module tb_conv1d_sys_sequencer;
    localparam int DW = 32;
    localparam int NT = 3;
    localparam int PL = 2;
    localparam int FD = 4;

    typedef struct {
        int                   len;
        logic [2:0][DW-1:0]   w;
        logic [3:0][DW-1:0]   x;
        bit                   toggle;
        bit                   poke;
        int                   xdelay;
        int                   ny;
        logic [5:0][DW-1:0]   y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   cfg_len = '0;
    logic          busy, done, pe_rst, pe_trigger;
    logic [DW-1:0] pe_din, pe_wen_idx, pe_wval, pe_sum;
`ifdef CONV1D_SEQ_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [6];

    conv1d_sys_sequencer_if #(.DW(DW)) bus ();

    conv1d_sys_sequencer #(
        .DW(DW), .NTAPS(NT), .LEN_W(16), .PIPE_LAT(PL), .FIFO_D(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .bus        (bus),
        .pe_rst     (pe_rst),
        .pe_trigger (pe_trigger),
        .pe_din     (pe_din),
        .pe_wen_idx (pe_wen_idx),
        .pe_wval    (pe_wval),
`ifdef CONV1D_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls),
`endif
        .pe_sum     (pe_sum)
    );

    always #5 clk = ~clk;

    // Behavioural 3-tap array: y = w0*x[n] + w1*x[n-1] + w2*x[n-2], sum valid PL cycles after trigger
    logic [DW-1:0] wm [NT];
    logic [DW-1:0] xs0, xs1, d0, d1, new_sum;
    assign new_sum = wm[0] * pe_din + wm[1] * xs0 + wm[2] * xs1;
    assign pe_sum  = d1;

    always @(posedge clk) begin
        if (pe_wen_idx >= 1 && pe_wen_idx <= NT) wm[pe_wen_idx - 1] <= pe_wval;
        if (pe_rst) begin
            xs0 <= '0; xs1 <= '0; d0 <= '0; d1 <= '0;
        end else begin
            if (pe_trigger) begin
                xs0 <= pe_din;
                xs1 <= xs0;
            end
            d0 <= pe_trigger ? new_sum : '0;
            d1 <= d0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int id);
        int wi = 0, xi = 0, ny = 0, cyc = 0, busy_cyc = 0, done_cyc = 0;
        int last_idx = -1, nlast = 0, nwen = 0, issued = 0, popped = 0;
        int max_out = 0, early = 0, first_trig = -1, last_trig = -1, exp_iss;
        bit done_seen = 1'b0, wen_ok = 1'b1, wf, xf, yf;
        logic [DW-1:0] ys [8];
        cfg_len = 16'(v.len);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.w_valid = 1'b1;      bus.w_data = v.w[0];
        bus.x_valid = (v.len > 0) && (v.xdelay == 0);
        bus.x_data  = v.x[0];
        bus.y_ready = v.toggle ? 1'b0 : 1'b1;
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            wf = bus.w_valid && bus.w_ready;
            xf = bus.x_valid && bus.x_ready;
            yf = bus.y_valid && bus.y_ready;
            if (busy) busy_cyc++;
            if (pe_wen_idx != 0) begin
                nwen++;
                if (pe_wen_idx != DW'(nwen)) wen_ok = 1'b0;
            end
            if (pe_trigger) begin
                issued++;
                if (first_trig < 0) first_trig = cyc;
                last_trig = cyc;
                if (issued - popped > max_out) max_out = issued - popped;
                if (cyc <= v.xdelay) early++;
            end
            if (yf) begin
                if (ny < 8) ys[ny] = bus.y_data;
                if (bus.y_last) begin last_idx = ny; nlast++; end
                ny++;
                popped++;
            end
            if (done) begin done_seen = 1'b1; done_cyc++; end
            @(posedge clk); #1;
            if (wf) wi++;
            if (xf) xi++;
            bus.w_valid = (wi < NT);
            bus.w_data  = (wi < NT) ? v.w[wi] : '0;
            bus.x_valid = (xi < v.len) && (cyc >= v.xdelay);
            bus.x_data  = (xi < v.len) ? v.x[xi] : '0;
            bus.y_ready = v.toggle ? ~bus.y_ready : 1'b1;
            start       = v.poke && (cyc == 3);
            cfg_len     = start ? 16'd3 : 16'(v.len);
        end
        bus.w_valid = 1'b0; bus.x_valid = 1'b0; bus.y_ready = 1'b1; start = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d done_seen", id), done_seen, 1);
        check($sformatf("v%0d done_width", id), done_cyc + int'(done), 1);
        check($sformatf("v%0d busy_after", id), busy, 0);
        check($sformatf("v%0d y_count", id), ny, v.ny);
        for (int i = 0; i < v.ny && i < ny; i++)
            check($sformatf("v%0d y[%0d]", id, i), ys[i], v.y[i]);
        check($sformatf("v%0d y_last_idx", id), last_idx, v.ny - 1);
        check($sformatf("v%0d y_last_count", id), nlast, (v.ny > 0) ? 1 : 0);
        check($sformatf("v%0d wen_count", id), nwen, NT);
        check($sformatf("v%0d wen_order", id), wen_ok, 1);
        check($sformatf("v%0d fifo_overcommit", id), (max_out <= FD) ? 1 : 0, 1);
        check($sformatf("v%0d early_trigger", id), early, 0);
        exp_iss = (v.len > 0) ? v.len + NT - 1 : 0;
        check($sformatf("v%0d issues", id), issued, exp_iss);
        if (!v.toggle && v.xdelay == 0 && v.len > 0)
            check($sformatf("v%0d no_bubbles", id), last_trig - first_trig + 1, issued);
`ifdef CONV1D_SEQ_PERF_EN
        check($sformatf("v%0d perf_cycles", id), perf_cycles, busy_cyc);
        if (v.toggle) check($sformatf("v%0d perf_stalls_nonzero", id), (perf_stalls > 0) ? 1 : 0, 1);
`endif
    endtask

    initial begin
        bit saw_trig;
        int ntrig;
        vecs[0] = '{len: 2, w: {32'd3, 32'd2, 32'd1}, x: {32'd0, 32'd0, 32'd1, 32'd1},
                    toggle: 0, poke: 0, xdelay: 0, ny: 4,
                    y: {32'd0, 32'd0, 32'd3, 32'd5, 32'd3, 32'd1}};
        vecs[1] = '{len: 4, w: {32'd3, 32'd2, 32'd1}, x: {32'd4, 32'd3, 32'd2, 32'd1},
                    toggle: 1, poke: 0, xdelay: 0, ny: 6,
                    y: {32'd12, 32'd17, 32'd16, 32'd10, 32'd4, 32'd1}};
        vecs[2] = '{len: 0, w: {32'd3, 32'd2, 32'd1}, x: '0,
                    toggle: 0, poke: 0, xdelay: 0, ny: 0, y: '0};
        vecs[3] = '{len: 1, w: {32'd3, 32'd5, 32'd7}, x: {32'd0, 32'd0, 32'd0, 32'd4},
                    toggle: 0, poke: 1, xdelay: 12, ny: 3,
                    y: {32'd0, 32'd0, 32'd0, 32'd12, 32'd20, 32'd28}};
        vecs[4] = '{len: 3, w: {32'd0, 32'd1, 32'hFFFF_FFFF},
                    x: {32'd0, 32'd1, 32'h8000_0000, 32'd2},
                    toggle: 0, poke: 0, xdelay: 0, ny: 5,
                    y: {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0002, 32'hFFFF_FFFE}};
        vecs[5] = '{len: 1, w: {32'd0, 32'd0, 32'd2}, x: {32'd0, 32'd0, 32'd0, 32'd5},
                    toggle: 0, poke: 0, xdelay: 0, ny: 3,
                    y: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10}};

        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.y_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst y_valid", bus.y_valid, 0);
        check("rst w_ready", bus.w_ready, 0);
        check("rst x_ready", bus.x_ready, 0);
        check("rst pe_trigger", pe_trigger, 0);
        check("rst pe_wen_idx", pe_wen_idx, 0);
        check("rst pe_rst", pe_rst, 0);

        for (int i = 0; i < 5; i++) run_job(vecs[i], i);

        // Abort a job mid-stream, then make sure the next job sees no stale sums
        cfg_len = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = 32'd9;
        bus.x_valid = 1'b1; bus.x_data = 32'd9;
        saw_trig = 1'b0; ntrig = 0;
        for (int c = 0; c < 40 && !saw_trig; c++) begin
            @(negedge clk);
            if (pe_trigger) ntrig++;
            if (ntrig >= 2) saw_trig = 1'b1;
            @(posedge clk); #1;
        end
        check("abort reached_stream", saw_trig, 1);
        rst = 1'b1;
        bus.w_valid = 1'b0; bus.x_valid = 1'b0;
        @(negedge clk);
        check("abort pe_rst_high", pe_rst, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy_low", busy, 0);
        check("abort y_valid_low", bus.y_valid, 0);
        run_job(vecs[5], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
